avmm_reg_arbiter2: RTL and testbench

//  Two-master Avalon-MM arbiter sharing one downstream register slave (DW-bit, fixed read latency).
//  - Sits between two upstream masters (ports A and B) and one control-register slave.
//  - Serialises accesses, stalls the losing master with waitrequest and returns captured readdata.
//  - One transfer at a time; no pipelining.

---
 rtl/avmm_reg_arbiter2.sv | 153 +++++++++++++++
 tb/tb_avmm_reg_arbiter2.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_reg_arbiter2.sv
`timescale 1ns/1ps
// avmm_reg_arbiter2: serialises two Avalon-MM masters onto one fixed-read-latency register slave.
// Optional `define ARB_ROUND_ROBIN_EN alternates tied grants; without it master A has fixed priority.
module avmm_reg_arbiter2 #(
  parameter int DW         = 8,
  parameter int AW         = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic          csi_MCLK_clk,
  input  logic          rsi_MRST_reset,
  input  logic [AW-1:0] avs_A_address,
  input  logic          avs_A_read,
  input  logic          avs_A_write,
  input  logic [DW-1:0] avs_A_writedata,
  output logic [DW-1:0] avs_A_readdata,
  output logic          avs_A_waitrequest,
  input  logic [AW-1:0] avs_B_address,
  input  logic          avs_B_read,
  input  logic          avs_B_write,
  input  logic [DW-1:0] avs_B_writedata,
  output logic [DW-1:0] avs_B_readdata,
  output logic          avs_B_waitrequest,
  output logic [AW-1:0] avm_R_address,
  output logic          avm_R_read,
  output logic          avm_R_write,
  output logic [DW-1:0] avm_R_writedata,
  input  logic [DW-1:0] avm_R_readdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arbState;

  localparam logic       PORT_A   = 1'b0;
  localparam logic       PORT_B   = 1'b1;
  localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY);

  arbState       state, stateNext;
  logic          reqA, reqB;
  logic          winner, winWrite;
  logic          grant, opWrite, capture;
  logic [1:0]    counter;
  logic [DW-1:0] readReg;

  assign reqA = avs_A_read | avs_A_write;
  assign reqB = avs_B_read | avs_B_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastGrant;

  // Resetting to B hands the very first tie to A.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      lastGrant <= PORT_B;
    end else if (state == IDLE && stateNext == ISSUE) begin
      lastGrant <= winner;
    end
  end
`endif

  always_comb begin
    winner = PORT_A;
    if (reqA && reqB) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = ~lastGrant;
`else
      winner = PORT_A;
`endif
    end else if (reqB) begin
      winner = PORT_B;
    end
  end

  // A port asserting read and write together is served as a write.
  assign winWrite = (winner == PORT_B) ? avs_B_write : avs_A_write;

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (reqA || reqB) stateNext = ISSUE;
      end
      ISSUE: begin
        if (opWrite) begin
          stateNext = DONE;
        end else if (RD_LATENCY == 0) begin
          capture   = 1'b1;
          stateNext = DONE;
        end else begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (counter == 2'd1) begin
          capture   = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Strobes are registered so they line up with the ISSUE state for exactly one clock.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      grant           <= PORT_A;
      opWrite         <= 1'b0;
      avm_R_address   <= '0;
      avm_R_writedata <= '0;
      avm_R_read      <= 1'b0;
      avm_R_write     <= 1'b0;
      counter         <= 2'd0;
      readReg         <= '0;
    end else begin
      avm_R_read  <= 1'b0;
      avm_R_write <= 1'b0;
      if (state == IDLE && stateNext == ISSUE) begin
        grant           <= winner;
        opWrite         <= winWrite;
        avm_R_address   <= (winner == PORT_B) ? avs_B_address : avs_A_address;
        avm_R_writedata <= (winner == PORT_B) ? avs_B_writedata : avs_A_writedata;
        avm_R_read      <= ~winWrite;
        avm_R_write     <= winWrite;
      end
      if (state == ISSUE && !opWrite) begin
        counter <= LAT_LOAD;
      end else if (state == WAIT) begin
        counter <= counter - 2'd1;
      end
      if (capture) begin
        readReg <= avm_R_readdata;
      end
    end
  end

  assign avs_A_waitrequest = reqA & ~(state == DONE && grant == PORT_A);
  assign avs_B_waitrequest = reqB & ~(state == DONE && grant == PORT_B);
  assign avs_A_readdata    = readReg;
  assign avs_B_readdata    = readReg;

endmodule

// File: tb/tb_avmm_reg_arbiter2.sv
`timescale 1ns/1ps
// tb_avmm_reg_arbiter2: three arbiters (read latency 1, 0, 3) each fronting a register slave model
// preset to 8'h5A; directed tables, corner sequences and a randomized run against a transaction model.
module tb_avmm_reg_arbiter2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]      aRd, aWr, bRd, bWr;
  logic [2:0][3:0] aAd, bAd;
  logic [2:0][7:0] aWd, bWd, aRdat, bRdat;
  logic [2:0]      aWait, bWait;
  logic [2:0]      mRead, mWrite;
  logic [2:0][3:0] mAddr;
  logic [2:0][7:0] mWdata, mRdata;

  int vectors = 0;
  int miscompares = 0;

  for (genvar g = 0; g < 3; g++) begin : gInst
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    logic [7:0] mem  [16];
    logic [7:0] pipe [4];

    avmm_reg_arbiter2 #(.DW(8), .AW(4), .RD_LATENCY(LAT)) dut (
      .csi_MCLK_clk      (clk),
      .rsi_MRST_reset    (rst),
      .avs_A_address     (aAd[g]),
      .avs_A_read        (aRd[g]),
      .avs_A_write       (aWr[g]),
      .avs_A_writedata   (aWd[g]),
      .avs_A_readdata    (aRdat[g]),
      .avs_A_waitrequest (aWait[g]),
      .avs_B_address     (bAd[g]),
      .avs_B_read        (bRd[g]),
      .avs_B_write       (bWr[g]),
      .avs_B_writedata   (bWd[g]),
      .avs_B_readdata    (bRdat[g]),
      .avs_B_waitrequest (bWait[g]),
      .avm_R_address     (mAddr[g]),
      .avm_R_read        (mRead[g]),
      .avm_R_write       (mWrite[g]),
      .avm_R_writedata   (mWdata[g]),
      .avm_R_readdata    (mRdata[g])
    );

    // Slave returns garbage (8'hEE) except exactly LAT clocks after its read strobe.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) mem[i] <= 8'h5A;
        for (int i = 0; i < 4; i++) pipe[i] <= 8'hEE;
      end else begin
        if (mWrite[g]) mem[mAddr[g]] <= mWdata[g];
        pipe[0] <= mRead[g] ? mem[mAddr[g]] : 8'hEE;
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign mRdata[g] = (LAT == 0) ? (mRead[g] ? mem[mAddr[g]] : 8'hEE) : pipe[(LAT == 0) ? 0 : LAT-1];
  end

  typedef struct {
    bit         portB;
    bit         rd;
    bit         wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] expData;
    int         expLat;
  } txnT;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int inst, input bit portB, input bit rd, input bit wr,
                               input logic [3:0] ad, input logic [7:0] wd);
    if (portB) begin
      bRd[inst] = rd; bWr[inst] = wr; bAd[inst] = ad; bWd[inst] = wd;
    end else begin
      aRd[inst] = rd; aWr[inst] = wr; aAd[inst] = ad; aWd[inst] = wd;
    end
  endtask

  // Single transfer from an idle arbiter; k counts sample points after the grant edge.
  task automatic runTxn(input int inst, input txnT t, input string tag);
    int lat, strobeK, nRd, nWr;
    logic [7:0] seenAddr, seenData, rdA, rdB;
    logic otherWait;
    @(negedge clk);
    applyStimulus(inst, t.portB, t.rd, t.wr, t.addr, t.wdata);
    lat = -1; strobeK = -1; nRd = 0; nWr = 0;
    seenAddr = 8'h00; seenData = 8'h00; rdA = 8'h00; rdB = 8'h00; otherWait = 1'b1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (mRead[inst] || mWrite[inst]) begin
        if (strobeK < 0) strobeK = k;
        seenAddr = 8'(mAddr[inst]);
        seenData = mWdata[inst];
      end
      nRd += int'(mRead[inst]);
      nWr += int'(mWrite[inst]);
      if (!(t.portB ? bWait[inst] : aWait[inst])) begin
        lat = k;
        rdA = aRdat[inst];
        rdB = bRdat[inst];
        otherWait = t.portB ? aWait[inst] : bWait[inst];
      end
    end
    applyStimulus(inst, t.portB, 1'b0, 1'b0, t.addr, t.wdata);
    checkOutput({tag, " latency"}, lat, t.expLat);
    checkOutput({tag, " strobe cycle"}, strobeK, 1);
    checkOutput({tag, " write strobes"}, nWr, int'(t.wr));
    checkOutput({tag, " read strobes"}, nRd, int'(t.rd & ~t.wr));
    checkOutput({tag, " address"}, seenAddr, 8'(t.addr));
    checkOutput({tag, " idle port wait"}, otherWait, 1'b0);
    if (t.wr) begin
      checkOutput({tag, " writedata"}, seenData, t.wdata);
    end else begin
      checkOutput({tag, " readdata A"}, rdA, t.expData);
      checkOutput({tag, " readdata B"}, rdB, t.expData);
    end
  endtask

  // Both ports issue the same op in the same clock; each drops its request once served.
  task automatic runPair(input bit rd, input bit wr, input logic [3:0] addr,
                         input logic [7:0] dA, input logic [7:0] dB,
                         output int latA, output int latB, output logic [7:0] rA, output logic [7:0] rB);
    @(negedge clk);
    applyStimulus(0, 1'b0, rd, wr, addr, dA);
    applyStimulus(0, 1'b1, rd, wr, addr, dB);
    latA = -1; latB = -1; rA = 8'h00; rB = 8'h00;
    for (int k = 1; k <= 30 && (latA < 0 || latB < 0); k++) begin
      @(negedge clk);
      if (latA < 0 && !aWait[0]) begin
        latA = k; rA = aRdat[0];
        applyStimulus(0, 1'b0, 1'b0, 1'b0, addr, dA);
      end
      if (latB < 0 && !bWait[0]) begin
        latB = k; rB = bRdat[0];
        applyStimulus(0, 1'b1, 1'b0, 1'b0, addr, dB);
      end
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b0, addr, dA);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, addr, dB);
  endtask

  task automatic newRequest(input bit portB);
    int r;
    r = $urandom_range(0, 7);
    applyStimulus(0, portB, (r <= 2) || (r == 6), (r >= 3) && (r <= 6),
                  4'($urandom_range(0, 3)), 8'($urandom));
  endtask

  txnT        tbl[8];
  txnT        latTbl[3];
  int         latA, latB, nDone, lat;
  logic [7:0] rA, rB, rdat;
  logic [3:0] seq;
  logic [3:0] expSeq;

  logic [7:0] modelMem [16];
  int         freeEdge, grantIv, doneIv;
  bit         mReqA, mReqB, win, winWr, lastWin;
  logic [3:0] winAddr;
  logic [7:0] winData, expRd;

  initial begin
    rst = 1'b1;
    aRd = '0; aWr = '0; bRd = '0; bWr = '0;
    aAd = '0; bAd = '0; aWd = '0; bWd = '0;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 8'h5A, 3};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 4'h1, 8'hC3, 8'h00, 2};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 4'h1, 8'h00, 8'hC3, 3};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 4'h2, 8'h77, 8'h00, 2};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 4'h2, 8'h00, 8'h77, 3};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 4'hF, 8'hFF, 8'h00, 2};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 4'hF, 8'h00, 8'hFF, 3};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 4'hE, 8'h00, 8'h5A, 3};

    latTbl[0] = '{1'b0, 1'b0, 1'b1, 4'h5, 8'h96, 8'h00, 2};
    latTbl[1] = '{1'b0, 1'b1, 1'b0, 4'h5, 8'h00, 8'h96, 0};
    latTbl[2] = '{1'b0, 1'b1, 1'b0, 4'h7, 8'h00, 8'h5A, 0};

    @(negedge clk);
    checkOutput("reset avm_R_read", mRead[0], 1'b0);
    checkOutput("reset avm_R_write", mWrite[0], 1'b0);
    checkOutput("reset avm_R_address", mAddr[0], 4'h0);
    checkOutput("reset avm_R_writedata", mWdata[0], 8'h00);
    checkOutput("reset readdata", aRdat[0], 8'h00);
    checkOutput("reset A wait", aWait[0], 1'b0);
    checkOutput("reset B wait", bWait[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) runTxn(0, tbl[i], $sformatf("tbl%0d", i));

    for (int inst = 1; inst <= 2; inst++) begin
      for (int i = 0; i < 3; i++) begin
        txnT t;
        t = latTbl[i];
        if (t.rd) t.expLat = (inst == 1) ? 2 : 5;
        runTxn(inst, t, $sformatf("lat%0d_%0d", (inst == 1) ? 0 : 3, i));
      end
    end

    runPair(1'b0, 1'b1, 4'h3, 8'h11, 8'h22, latA, latB, rA, rB);
    checkOutput("tie write A latency", latA, 2);
    checkOutput("tie write B latency", latB, 5);
    runPair(1'b1, 1'b0, 4'h3, 8'h00, 8'h00, latA, latB, rA, rB);
    checkOutput("tie read A latency", latA, 3);
    checkOutput("tie read B latency", latB, 7);
    checkOutput("tie read A data", rA, 8'h22);
    checkOutput("tie read B data", rB, 8'h22);

    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 4'h3, 8'h00);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 4'h3, 8'h00);
    seq = 4'h0; nDone = 0;
    for (int k = 0; k < 40 && nDone < 4; k++) begin
      @(negedge clk);
      if (!aWait[0]) begin
        seq = {seq[2:0], 1'b0}; nDone++;
      end else if (!bWait[0]) begin
        seq = {seq[2:0], 1'b1}; nDone++;
      end
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
`ifdef ARB_ROUND_ROBIN_EN
    expSeq = 4'b0101;
`else
    expSeq = 4'b0000;
`endif
    checkOutput("contention grant count", nDone, 4);
    checkOutput("contention grant order", seq, expSeq);

    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 4'h9, 8'h00);
    @(negedge clk);
    checkOutput("pre-reset read strobe", mRead[0], 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid reset read strobe", mRead[0], 1'b0);
    checkOutput("mid reset write strobe", mWrite[0], 1'b0);
    checkOutput("mid reset address", mAddr[0], 4'h0);
    checkOutput("mid reset B wait", bWait[0], 1'b1);
    checkOutput("mid reset readdata", bRdat[0], 8'h00);
    @(negedge clk);
    checkOutput("held reset read strobe", mRead[0], 1'b0);
    checkOutput("held reset B wait", bWait[0], 1'b1);
    rst = 1'b0;
    lat = -1; rdat = 8'h00;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (!bWait[0]) begin
        lat = k; rdat = bRdat[0];
      end
    end
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    checkOutput("post-reset read latency", lat, 3);
    checkOutput("post-reset read data", rdat, 8'h5A);

    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) modelMem[i] = 8'h5A;
    freeEdge = 0; grantIv = -100; doneIv = -100;
    lastWin = 1'b1; win = 1'b0; winWr = 1'b0; winAddr = 4'h0; winData = 8'h00; expRd = 8'h00;
    newRequest(1'b0);
    newRequest(1'b1);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      mReqA = aRd[0] | aWr[0];
      mReqB = bRd[0] | bWr[0];
      if (i >= freeEdge && (mReqA || mReqB)) begin
        if (mReqA && mReqB) begin
`ifdef ARB_ROUND_ROBIN_EN
          win = ~lastWin;
`else
          win = 1'b0;
`endif
        end else begin
          win = mReqB;
        end
        lastWin = win;
        winWr   = win ? bWr[0] : aWr[0];
        winAddr = win ? bAd[0] : aAd[0];
        winData = win ? bWd[0] : aWd[0];
        grantIv  = i;
        doneIv   = i + 1 + (winWr ? 0 : 1);
        freeEdge = doneIv + 2;
        if (winWr) modelMem[winAddr] = winData;
        else       expRd = modelMem[winAddr];
      end
      @(negedge clk);
      checkOutput("rand A wait", aWait[0], mReqA && !(i == doneIv && !win));
      checkOutput("rand B wait", bWait[0], mReqB && !(i == doneIv && win));
      checkOutput("rand read strobe", mRead[0], (i == grantIv) && !winWr);
      checkOutput("rand write strobe", mWrite[0], (i == grantIv) && winWr);
      if (i == grantIv) begin
        checkOutput("rand address", mAddr[0], winAddr);
        if (winWr) checkOutput("rand writedata", mWdata[0], winData);
      end
      if (i == doneIv && !winWr) begin
        checkOutput("rand readdata", win ? bRdat[0] : aRdat[0], expRd);
      end
      if (mReqA && !aWait[0]) newRequest(1'b0);
      else if (!mReqA && $urandom_range(0, 1) == 1) newRequest(1'b0);
      if (mReqB && !bWait[0]) newRequest(1'b1);
      else if (!mReqB && $urandom_range(0, 1) == 1) newRequest(1'b1);
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
